disp2depth_pipe: RTL and testbench
==================================

Name: disp2depth_pipe

Overview:
- Streaming, stallable disparity-to-depth converter for the SGM output path. Successor to the fixed-format disp2depth unit.
- Computes depth = BF / disparity for one pixel per cycle, using a fully pipelined restoring divider.
- All widths are parametrised: fixed-point disparity, per-pixel baseline×focal constant, and a selectable output mode.
- Adds a valid/ready handshake with backpressure, invalid/overflow handling, and a per-frame invalid-pixel counter.

Parameters:
- DISP_W, 16, disparity input width (unsigned fixed point).
- DISP_FRAC, 4, number of fractional bits in disp.
- BF_W, 24, width of the baseline×focal constant (unsigned integer, depth units × pixels).
- DEPTH_W, 16, output width; also the number of divider stages.
- MIN_DISP, 1, raw disp below this value is invalid.
- INVALID_VAL, 0, output code for invalid disparity.
- CNT_W, 24, invalid counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts the pixel this cycle.
- in_sof  in  1  first pixel of frame, qualified by the accept.
- disp  in  DISP_W  disparity.
- bf  in  BF_W  baseline×focal constant, sampled per pixel at accept.
- mode  in  1  0 = depth output, 1 = disparity bypass; sampled per pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  in_sof delayed with its pixel.
- depth  out  DEPTH_W  result.
- out_flag  out  2  per-pixel status: 00 ok, 01 invalid, 10 saturated, 11 unused.
- invalid_cnt  out  CNT_W  invalid pixels accepted in the current frame.

Behaviour:
- **Accept and advance.** accept = in_valid & in_ready. Global advance = ~out_valid | out_ready. in_ready = advance, combinational.
- **Pipeline stalls.** When advance = 0, every stage register and valid bit holds. There is no data loss or reordering.
- **Pipeline structure.** Stage 0 registers:
  - N = bf << DISP_FRAC, width BF_W+DISP_FRAC.
  - disp, mode, sof.
  - inv = (disp < MIN_DISP).
  - ovf = (N >= disp << DEPTH_W), computed at full width so there is no truncation.
- **Divider stages.** Stages 1..DEPTH_W each resolve one quotient bit, MSB first, by restoring compare-subtract. Partial remainder width is DISP_W+1. Each stage carries disp, flags, sof and a valid bit.
- **Output stage.** Registers depth and flags with this priority:
  - inv → INVALID_VAL, flag 01.
  - mode=1 → integer part of disp (disp >> DISP_FRAC), saturated to DEPTH_W bits, flag 00 (10 if saturated).
  - ovf → 2^DEPTH_W−1, flag 10.
  - otherwise quotient, flag 00.
- **Latency.** DEPTH_W+2 advancing cycles from accept to out_valid. Throughput is 1 pixel/cycle when out_ready = 1.
- **Bubbles.** in_valid = 0 inserts a bubble; the stage valid bit is 0. Bubbles do not collapse when advance = 1; they propagate.
- **Invalid counter.**
  - On accept with in_sof: invalid_cnt ← inv ? 1 : 0.
  - On accept without in_sof: invalid_cnt increments when inv, saturating at all-ones.
- **Parameter changes.** bf/mode changes apply only to pixels accepted afterwards. In-flight pixels keep their sampled values.
- **Reset.** rst (sync, active high) clears all valid bits. Reset values:
  - out_valid = 0
  - depth = 0
  - out_flag = 0
  - out_sof = 0
  - invalid_cnt = 0

  Reset mid-frame discards all in-flight pixels. in_ready is 1 in the cycle after reset deasserts.
- **Simultaneous events.** Stall and reset in the same cycle: reset wins.
- **Divide by zero.** disp = 0 is always invalid when MIN_DISP ≥ 1, so the divider never divides by zero. If MIN_DISP = 0, disp = 0 yields ovf → saturated.

Optional Feature:
- Macro: DISP2DEPTH_ROUND_EN.
- Defined: stage 0 numerator is N = (bf << DISP_FRAC) + (disp >> 1), i.e. round-to-nearest, ties up. The ovf check uses the rounded N.
- Undefined: N = bf << DISP_FRAC, i.e. truncating floor. The ovf check uses the unrounded N.
- Latency and interface are identical in both builds.

Test Plan:
- Basic division: defaults, bf=100000, disp=0x0640 (100.0), mode=0, out_ready=1 → after 18 cycles depth=1000 (0x03E8), flag 00.
- Invalid and saturation:
  - disp=0x0000 → depth=0, flag 01.
  - bf=100000, disp=0x0001 → depth=0xFFFF, flag 10.
  - invalid_cnt=1 after the sof pixel with disp=0.
- Rounding: bf=5, disp=0x0030 (3.0) → depth=1 without DISP2DEPTH_ROUND_EN, depth=2 with it.
- Backpressure: continuous in_valid with incrementing disp; out_ready low for 5 cycles mid-stream.
  - in_ready=0 in those same cycles.
  - Output sequence complete, in order, no duplicates.
  - Throughput returns to 1/cycle.
- Mode bypass and counter: mode=1, disp=0x0645 → depth=100. Frame of 10 pixels with 3 disp=0 → invalid_cnt=3. The next in_sof pixel (valid) → invalid_cnt=0.
- Reset mid-stream: assert rst for 1 cycle with 10 pixels in flight → next cycle out_valid=0, invalid_cnt=0. No stale outputs appear afterwards.

Source files
------------

// File: rtl/disp2depth_pipe.sv
// Stallable disparity-to-depth converter: depth = BF / disp through a fully pipelined restoring divider.
// Optional macro DISP2DEPTH_ROUND_EN selects round-to-nearest (ties up) instead of truncating division.
module disp2depth_pipe #(
  parameter int DISP_W      = 16,
  parameter int DISP_FRAC   = 4,
  parameter int BF_W        = 24,
  parameter int DEPTH_W     = 16,
  parameter int MIN_DISP    = 1,
  parameter int INVALID_VAL = 0,
  parameter int CNT_W       = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [DISP_W-1:0]  disp,
  input  logic [BF_W-1:0]    bf,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic [DEPTH_W-1:0] depth,
  output logic [1:0]         out_flag,
  output logic [CNT_W-1:0]   invalid_cnt
);

  // One spare numerator bit keeps the rounding addend from wrapping.
  localparam int NW = BF_W + DISP_FRAC + 1;
  localparam int CW = NW + DISP_W + DEPTH_W;
  localparam int EW = DISP_W + DEPTH_W;
  localparam int S  = DEPTH_W;

  logic advance;
  logic accept;
  logic [NW-1:0] num_in;
  logic inv_in;
  logic ovf_in;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

`ifdef DISP2DEPTH_ROUND_EN
  assign num_in = (NW'(bf) << DISP_FRAC) + NW'(disp >> 1);
`else
  assign num_in = NW'(bf) << DISP_FRAC;
`endif

  assign inv_in = disp < DISP_W'(MIN_DISP);
  assign ovf_in = CW'(num_in) >= (CW'(disp) << DEPTH_W);

  logic [S:0]         v_q;
  logic [S:0]         mode_q;
  logic [S:0]         sof_q;
  logic [S:0]         inv_q;
  logic [S:0]         ovf_q;
  logic [DISP_W-1:0]  disp_q [0:S];
  logic [DISP_W-1:0]  rem_q  [0:S-1];
  logic [DEPTH_W-1:0] num_q  [0:S-1];
  logic [DEPTH_W-1:0] quo_q  [0:S];

  logic [DISP_W:0] trial [1:S];
  logic [S:1]      ge;

  // Each stage shifts the next numerator bit into the remainder and tries to subtract the divisor.
  always_comb begin
    for (int k = 1; k <= S; k++) begin
      trial[k] = {rem_q[k-1], num_q[k-1][DEPTH_W-1]};
      ge[k]    = trial[k] >= {1'b0, disp_q[k-1]};
    end
  end

  logic [EW-1:0]      int_ext;
  logic               int_sat;
  logic [DEPTH_W-1:0] depth_d;
  logic [1:0]         flag_d;

  assign int_ext = EW'(disp_q[S] >> DISP_FRAC);
  assign int_sat = (int_ext >> DEPTH_W) != '0;

  always_comb begin
    depth_d = quo_q[S];
    flag_d  = 2'b00;
    if (inv_q[S]) begin
      depth_d = DEPTH_W'(INVALID_VAL);
      flag_d  = 2'b01;
    end else if (mode_q[S]) begin
      if (int_sat) begin
        depth_d = '1;
        flag_d  = 2'b10;
      end else begin
        depth_d = DEPTH_W'(int_ext);
      end
    end else if (ovf_q[S]) begin
      depth_d = '1;
      flag_d  = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid   <= 1'b0;
      depth       <= '0;
      out_flag    <= 2'b00;
      out_sof     <= 1'b0;
      invalid_cnt <= '0;
    end else begin
      if (advance) begin
        v_q[0]    <= in_valid;
        disp_q[0] <= disp;
        mode_q[0] <= mode;
        sof_q[0]  <= in_sof;
        inv_q[0]  <= inv_in;
        ovf_q[0]  <= ovf_in;
        // When no overflow, the bits above DEPTH_W are already smaller than disp.
        rem_q[0]  <= DISP_W'(num_in >> DEPTH_W);
        num_q[0]  <= DEPTH_W'(num_in);
        quo_q[0]  <= '0;
        for (int k = 1; k <= S; k++) begin
          v_q[k]    <= v_q[k-1];
          disp_q[k] <= disp_q[k-1];
          mode_q[k] <= mode_q[k-1];
          sof_q[k]  <= sof_q[k-1];
          inv_q[k]  <= inv_q[k-1];
          ovf_q[k]  <= ovf_q[k-1];
          quo_q[k]  <= (quo_q[k-1] << 1) | DEPTH_W'(ge[k]);
        end
        for (int k = 1; k < S; k++) begin
          rem_q[k] <= DISP_W'(ge[k] ? trial[k] - {1'b0, disp_q[k-1]} : trial[k]);
          num_q[k] <= num_q[k-1] << 1;
        end
        out_valid <= v_q[S];
        out_sof   <= sof_q[S];
        depth     <= depth_d;
        out_flag  <= flag_d;
      end
      if (accept) begin
        if (in_sof) begin
          invalid_cnt <= CNT_W'(inv_in);
        end else if (inv_in && invalid_cnt != '1) begin
          invalid_cnt <= invalid_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_disp2depth_pipe.sv
// Self-checking bench for disp2depth_pipe: directed cases plus randomized traffic against a queue-based model.
module tb_disp2depth_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [15:0] disp;
  logic [23:0] bf;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic [15:0] depth;
  logic [1:0]  out_flag;
  logic [23:0] invalid_cnt;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;
  int model_cnt = 0;
  bit started = 1'b0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  logic [17:0] mon_r;

  always #5 clk = ~clk;

  disp2depth_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .disp(disp), .bf(bf), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .depth(depth), .out_flag(out_flag), .invalid_cnt(invalid_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: depth = bf*16/disp as plain integer arithmetic, returns {flag, depth}.
  function automatic logic [17:0] refDepth(input logic [15:0] d, input logic [23:0] b, input logic m);
    longint n;
    longint ip;
    n = longint'(b) * 16;
`ifdef DISP2DEPTH_ROUND_EN
    n = n + longint'(d) / 2;
`endif
    if (d == 16'd0) return {2'b01, 16'h0000};
    if (m) begin
      ip = longint'(d) / 16;
      if (ip > 65535) return {2'b10, 16'hFFFF};
      return {2'b00, ip[15:0]};
    end
    if (n >= longint'(d) * 65536) return {2'b10, 16'hFFFF};
    n = n / longint'(d);
    return {2'b00, n[15:0]};
  endfunction

  // Downstream ready pattern: 0 always ready, 1 random, 2 held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: handshakes are observed mid-cycle, when inputs are stable until the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else if (started) begin
      checkOutput("invalid_cnt", invalid_cnt, model_cnt);
      checkOutput("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("depth", depth, mon_e[15:0]);
          checkOutput("flag", out_flag, mon_e[17:16]);
          checkOutput("sof", out_sof, mon_e[18]);
        end
      end
      if (in_valid && in_ready) begin
        mon_r = refDepth(disp, bf, mode);
        exp_q.push_back({in_sof, mon_r});
        if (in_sof) model_cnt = (disp == 16'd0) ? 1 : 0;
        else if (disp == 16'd0 && model_cnt < 24'hFFFFFF) model_cnt++;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [23:0] b,
                               input logic m, input logic s);
    int tries = 0;
    @(posedge clk);
    #1;
    in_valid = v;
    disp = d;
    bf = b;
    mode = m;
    in_sof = s;
    @(negedge clk);
    if (v) begin
      while (!in_ready && tries < 200) begin
        @(posedge clk);
        @(negedge clk);
        tries++;
      end
      if (!in_ready) checkOutput("ready_timeout", in_ready, 1);
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic waitOutput(input string tag, input logic [15:0] expd, input logic [1:0] expf);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput({tag, "_timeout"}, out_valid, 1);
    else begin
      checkOutput({tag, "_depth"}, depth, expd);
      checkOutput({tag, "_flag"}, out_flag, expf);
    end
  endtask

  task automatic sendOne(input string tag, input logic [15:0] d, input logic [23:0] b, input logic m,
                         input logic s, input logic [15:0] expd, input logic [1:0] expf);
    applyStimulus(1'b1, d, b, m, s);
    idleCycle();
    waitOutput(tag, expd, expf);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int c0;
    logic [15:0] d;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    disp = '0;
    bf = '0;
    mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_depth", depth, 0);
    checkOutput("rst_flag", out_flag, 0);
    checkOutput("rst_sof", out_sof, 0);
    checkOutput("rst_cnt", invalid_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] basic division and latency");
    applyStimulus(1'b1, 16'h0640, 24'd100000, 1'b0, 1'b1);
    idleCycle();
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("latency", lat, 18);
    checkOutput("basic_depth", depth, 16'd1000);
    checkOutput("basic_flag", out_flag, 2'b00);
    drain();

    $display("[TB] invalid, saturation, rounding, bypass");
    sendOne("disp_zero", 16'h0000, 24'd100000, 1'b0, 1'b1, 16'h0000, 2'b01);
    checkOutput("inv_cnt_one", invalid_cnt, 1);
    sendOne("ovf", 16'h0001, 24'd100000, 1'b0, 1'b0, 16'hFFFF, 2'b10);
`ifdef DISP2DEPTH_ROUND_EN
    sendOne("rounding", 16'h0030, 24'd5, 1'b0, 1'b0, 16'd2, 2'b00);
`else
    sendOne("rounding", 16'h0030, 24'd5, 1'b0, 1'b0, 16'd1, 2'b00);
`endif
    sendOne("bypass", 16'h0645, 24'd5, 1'b1, 1'b0, 16'd100, 2'b00);
    drain();

    $display("[TB] invalid counter frame");
    for (int i = 0; i < 10; i++) begin
      d = (i == 2 || i == 5 || i == 8) ? 16'h0000 : 16'h0200 + 16'(i);
      applyStimulus(1'b1, d, 24'd1000, 1'b0, i == 0);
    end
    idleCycle();
    @(negedge clk);
    checkOutput("frame_inv_cnt", invalid_cnt, 3);
    drain();
    sendOne("sof_bypass", 16'h0645, 24'd1000, 1'b1, 1'b1, 16'd100, 2'b00);
    checkOutput("new_frame_cnt", invalid_cnt, 0);
    drain();

    $display("[TB] backpressure");
    fork
      begin
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 24'd500000, 1'b0, i == 0);
        idleCycle();
      end
      begin
        repeat (25) @(posedge clk);
        #1;
        ready_mode = 2;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        c0 = xfer_cnt;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("throughput", 32'(xfer_cnt - c0), 10);
      end
    join
    drain();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, (i == 3) ? 16'h0000 : 16'h0400 + 16'(i), 24'd70000, 1'b0, i == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_cnt", invalid_cnt, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    checkOutput("post_reset_queue", exp_q.size(), 0);

    $display("[TB] randomized traffic");
    ready_mode = 1;
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [23:0] b;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       d = 16'h0000;
        1:       d = 16'($urandom_range(1, 15));
        2:       d = 16'($urandom_range(16'hF000, 16'hFFFF));
        default: d = 16'($urandom);
      endcase
      b = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 4000)) : 24'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, d, b, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    idleCycle();
    ready_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
